seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_muldiv_engine.sv | 147 ++++++++++++++
 rtl/seq_alu.sv | 210 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   - 5-bit opcode encodings
//   - FSM state encoding (also exported on the top-level debug port)
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_MUL_ITER = 3'd2,
    S_DIV_ITER = 3'd3,
    S_DONE     = 3'd4
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_engine.sv
// -----------------------------------------------------------------------------
// alu_muldiv_engine
// Iterative signed multiply / divide datapath.
//   MUL: radix-2 Booth, one step per cycle, WIDTH steps.
//   DIV: restoring division on magnitudes, one quotient bit per cycle for
//        WIDTH cycles, then one sign-fix cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load_i          capture operands and mode, clear the step counter
//   is_div_i        mode sampled with load_i (1 = divide, 0 = multiply)
//   run_i           advance one step this cycle
//   a_i, b_i        operands (a = multiplicand / dividend)
//   last_o          the current cycle is the final step of the operation
//   res_hi_o/lo_o   result as it will stand after the current step; only
//                   meaningful while last_o is high
//                   (MUL: product high/low, DIV: remainder/quotient)
// -----------------------------------------------------------------------------
module alu_muldiv_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             is_div_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  localparam int CW = $clog2(WIDTH + 1) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  // acc_q: Booth accumulator (MUL) / partial remainder (DIV), one guard bit.
  // qr_q : multiplier shifting out (MUL) / dividend in, quotient out (DIV).
  // m_q  : multiplicand (MUL) / divisor magnitude (DIV).
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] qr_q;
  logic [WIDTH-1:0] m_q;
  logic             qm1_q;
  logic             is_div_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   mul_acc_d;
  logic [WIDTH-1:0] mul_qr_d;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_acc_d;
  logic [WIDTH-1:0] div_qr_d;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Booth step: add/subtract the sign-extended multiplicand depending on the
  // bit pair {Q[0], Q[-1]}, then arithmetic-shift {A, Q} right by one.
  always_comb begin
    mul_sum = acc_q;
    case ({qr_q[0], qm1_q})
      2'b01:   mul_sum = acc_q + {m_q[WIDTH-1], m_q};
      2'b10:   mul_sum = acc_q - {m_q[WIDTH-1], m_q};
      default: mul_sum = acc_q;
    endcase
    mul_acc_d = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
    mul_qr_d  = {mul_sum[0], qr_q[WIDTH-1:1]};
  end

  // Restoring step: shift the next dividend bit into the remainder and keep
  // the trial difference only when it is non-negative.
  always_comb begin
    div_shift = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, m_q};
    if (!div_trial[WIDTH]) begin
      div_acc_d = div_trial;
      div_qr_d  = {qr_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_d = div_shift;
      div_qr_d  = {qr_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix: quotient negative when operand signs differ, remainder takes
  // the dividend's sign (truncating division).
  always_comb begin
    rem_mag = acc_q[WIDTH-1:0];
    quo_fix = neg_quo_q ? -qr_q : qr_q;
    rem_fix = neg_rem_q ? -rem_mag : rem_mag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      qr_q      <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      is_div_q <= is_div_i;
      if (is_div_i) begin
        qr_q      <= a_i[WIDTH-1] ? -a_i : a_i;
        m_q       <= b_i[WIDTH-1] ? -b_i : b_i;
        neg_quo_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
        neg_rem_q <= a_i[WIDTH-1];
      end else begin
        qr_q      <= b_i;
        m_q       <= a_i;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
      end
    end else if (run_i) begin
      cnt_q <= cnt_q + CW'(1);
      if (is_div_q) begin
        if (cnt_q != DIV_LAST) begin
          acc_q <= div_acc_d;
          qr_q  <= div_qr_d;
        end
      end else begin
        acc_q <= mul_acc_d;
        qr_q  <= mul_qr_d;
        qm1_q <= qr_q[0];
      end
    end
  end

  always_comb begin
    last_o = is_div_q ? (cnt_q == DIV_LAST) : (cnt_q == MUL_LAST);
    if (is_div_q) begin
      res_hi_o = rem_fix;
      res_lo_o = quo_fix;
    end else begin
      res_hi_o = mul_acc_d[WIDTH-1:0];
      res_lo_o = mul_qr_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative signed
// multiply and divide (delegated to alu_muldiv_engine).
// Ports:
//   clock        rising-edge clock
//   clear        asynchronous active-high reset
//   start        one-cycle request; samples opcode, Ra, Rb when idle
//   opcode       operation code (see alu_pkg)
//   Ra, Rb       operands (Ra = multiplicand / dividend)
//   busy         operation in progress
//   done         one-cycle completion pulse
//   ZHI, ZLO     result high / low halves
//   div_by_zero  divide-by-zero flag of the last completed operation
//   dbg_state_o  current FSM state
//
// Handshake: a start is accepted only in a cycle where busy=0 (state IDLE);
// the rising edge that samples it latches opcode and operands. busy is high
// from the next cycle through the done cycle inclusive; any start seen while
// busy=1 (including the done cycle) is dropped. ZHI/ZLO/div_by_zero change
// only on the edge that raises done and hold until the next done.
// -----------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ZHI,
  output logic [WIDTH-1:0] ZLO,
  output logic             div_by_zero,
  output alu_state_e       dbg_state_o
);

  alu_state_e       state_q, state_d;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] zhi_q, zhi_d;
  logic [WIDTH-1:0] zlo_q, zlo_d;
  logic             dbz_q, dbz_d;

  logic             latch_en;
  logic             out_en;
  logic             eng_load;
  logic             eng_run;
  logic             eng_last;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] eng_lo;

  logic [WIDTH-1:0]   exec_hi;
  logic [WIDTH-1:0]   exec_lo;
  logic               exec_dbz;
  logic [SHW-1:0]     sh_amt;
  logic [2*WIDTH-1:0] rot_src;
  logic [2*WIDTH-1:0] rot_r;
  logic [2*WIDTH-1:0] rot_l;

  // ---------------------------------------------------------------------------
  // Single-cycle operations on the latched operands
  // ---------------------------------------------------------------------------
  always_comb begin
    sh_amt   = b_q[SHW-1:0];
    // Rotates shift a doubled copy so that an amount of 0 needs no special case.
    rot_src  = {a_q, a_q};
    rot_r    = rot_src >> sh_amt;
    rot_l    = rot_src << sh_amt;
    exec_hi  = '0;
    exec_lo  = '0;
    exec_dbz = 1'b0;
    case (op_q)
      OP_ADD: exec_lo = a_q + b_q;
      OP_SUB: exec_lo = a_q - b_q;
      OP_SHR: exec_lo = a_q >> sh_amt;
      OP_SHL: exec_lo = a_q << sh_amt;
      OP_ROR: exec_lo = rot_r[WIDTH-1:0];
      OP_ROL: exec_lo = rot_l[2*WIDTH-1:WIDTH];
      OP_AND: exec_lo = a_q & b_q;
      OP_OR:  exec_lo = a_q | b_q;
      OP_NEG: exec_lo = -a_q;
      OP_NOT: exec_lo = ~a_q;
      // A divide only reaches EXEC when the divisor is zero.
      OP_DIV: begin
        exec_lo  = '1;
        exec_hi  = a_q;
        exec_dbz = 1'b1;
      end
      default: begin
        exec_hi  = '0;
        exec_lo  = '0;
        exec_dbz = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    eng_load = 1'b0;
    out_en   = 1'b0;
    zhi_d    = zhi_q;
    zlo_d    = zlo_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          if (opcode == OP_MUL) begin
            eng_load = 1'b1;
            state_d  = S_MUL_ITER;
          end else if ((opcode == OP_DIV) && (Rb != '0)) begin
            eng_load = 1'b1;
            state_d  = S_DIV_ITER;
          end else begin
            state_d  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        out_en  = 1'b1;
        zhi_d   = exec_hi;
        zlo_d   = exec_lo;
        dbz_d   = exec_dbz;
        state_d = S_DONE;
      end
      S_MUL_ITER, S_DIV_ITER: begin
        if (eng_last) begin
          out_en  = 1'b1;
          zhi_d   = eng_hi;
          zlo_d   = eng_lo;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (latch_en) begin
      op_q <= opcode;
      a_q  <= Ra;
      b_q  <= Rb;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      zhi_q <= '0;
      zlo_q <= '0;
      dbz_q <= 1'b0;
    end else if (out_en) begin
      zhi_q <= zhi_d;
      zlo_q <= zlo_d;
      dbz_q <= dbz_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Iterative MUL/DIV engine
  // ---------------------------------------------------------------------------
  assign eng_run = (state_q == S_MUL_ITER) || (state_q == S_DIV_ITER);

  alu_muldiv_engine #(
    .WIDTH (WIDTH)
  ) u_engine (
    .clk      (clock),
    .rst      (clear),
    .load_i   (eng_load),
    .is_div_i (opcode == OP_DIV),
    .run_i    (eng_run),
    .a_i      (Ra),
    .b_i      (Rb),
    .last_o   (eng_last),
    .res_hi_o (eng_hi),
    .res_lo_o (eng_lo)
  );

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign ZHI         = zhi_q;
  assign ZLO         = zlo_q;
  assign div_by_zero = dbz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import alu_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  logic        start = 1'b0;
  logic        sel16 = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] ra = '0;
  logic [31:0] rb = '0;

  logic        busy32, done32, dbz32;
  logic [31:0] zhi32, zlo32;
  alu_state_e  dbg32;
  logic        busy16, done16, dbz16;
  logic [15:0] zhi16, zlo16;
  alu_state_e  dbg16;

  seq_alu #(.WIDTH(32)) dut32 (
    .clock(clock), .clear(clear), .start(start & ~sel16), .opcode(opcode),
    .Ra(ra), .Rb(rb), .busy(busy32), .done(done32), .ZHI(zhi32), .ZLO(zlo32),
    .div_by_zero(dbz32), .dbg_state_o(dbg32)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clock(clock), .clear(clear), .start(start & sel16), .opcode(opcode),
    .Ra(ra[15:0]), .Rb(rb[15:0]), .busy(busy16), .done(done16), .ZHI(zhi16), .ZLO(zlo16),
    .div_by_zero(dbz16), .dbg_state_o(dbg16)
  );

  logic        busy_m, done_m, dbz_m;
  logic [31:0] zhi_m, zlo_m;
  alu_state_e  dbg_m;
  assign busy_m = sel16 ? busy16 : busy32;
  assign done_m = sel16 ? done16 : done32;
  assign dbz_m  = sel16 ? dbz16  : dbz32;
  assign zhi_m  = sel16 ? {16'h0, zhi16} : zhi32;
  assign zlo_m  = sel16 ? {16'h0, zlo16} : zlo32;
  assign dbg_m  = sel16 ? dbg16 : dbg32;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic at width w.
  function automatic void ref_model(input int w, input logic [4:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo,
                                    output logic dbz, output int lat);
    longint unsigned mask, ua, ub, t;
    longint sa, sb, p, q, r;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'h0, a} & mask;
    ub = {32'h0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (((ua >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
    if (((ub >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
    sh  = int'(ub % longint'(w));
    hi  = '0;
    lo  = '0;
    dbz = 1'b0;
    lat = 2;
    t   = 0;
    case (op)
      OP_ADD: t = ua + ub;
      OP_SUB: t = ua - ub;
      OP_SHR: t = ua >> sh;
      OP_SHL: t = ua << sh;
      OP_ROR: t = (ua >> sh) | (ua << (w - sh));
      OP_ROL: t = (ua << sh) | (ua >> (w - sh));
      OP_AND: t = ua & ub;
      OP_OR:  t = ua | ub;
      OP_NEG: t = -ua;
      OP_NOT: t = ~ua;
      OP_MUL: begin
        p   = sa * sb;
        t   = longint'(p) & mask;
        hi  = 32'((p >>> w) & longint'(mask));
        lat = w + 1;
      end
      OP_DIV: begin
        if (sb == 0) begin
          t   = mask;
          hi  = 32'(ua);
          dbz = 1'b1;
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          t   = longint'(q) & mask;
          hi  = 32'(r & longint'(mask));
          lat = w + 2;
        end
      end
      default: t = 0;
    endcase
    lo = 32'(t & mask);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: called right after a falling edge; returns right after a falling
  // edge in the IDLE cycle following done. inj >= 1 raises a stray ADD start
  // in that cycle of the operation.
  // ---------------------------------------------------------------------------
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj);
    logic [31:0] e_hi, e_lo;
    logic        e_dbz;
    int          lat, n, w;
    logic        busy_ok;
    w = sel16 ? 16 : 32;
    ref_model(w, op, a, b, e_hi, e_lo, e_dbz, lat);
    exp_q.push_back(e_lo);
    opcode = op; ra = a; rb = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0; opcode = 5'($urandom); ra = $urandom; rb = $urandom;
    n = 1;
    busy_ok = 1'b1;
    while (!done_m && n < 200) begin
      if (!busy_m) busy_ok = 1'b0;
      start = (n == inj);
      if (n == inj) opcode = OP_ADD;
      @(negedge clock);
      n++;
    end
    check($sformatf("latency op=%0h w=%0d", op, w), 64'(n), 64'(lat));
    check($sformatf("busy op=%0h", op), {62'h0, busy_m, busy_ok}, 64'h3);
    check($sformatf("zhi op=%0h a=%0h b=%0h", op, a, b), 64'(zhi_m), 64'(e_hi));
    check($sformatf("zlo op=%0h a=%0h b=%0h", op, a, b), 64'(zlo_m), 64'(exp_q.pop_front()));
    check($sformatf("dbz op=%0h", op), 64'(dbz_m), 64'(e_dbz));
    // A start in the done cycle must be dropped.
    start = 1'b1; opcode = OP_ADD; ra = $urandom; rb = $urandom;
    @(negedge clock);
    start = 1'b0;
    check("start_in_done_ignored", {62'h0, busy_m, done_m}, 64'h0);
    check("hold_zlo", 64'(zlo_m), 64'(e_lo));
  endtask

  task automatic abort_div();
    int dones;
    opcode = OP_DIV; ra = 32'hFFFF_FF9C; rb = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    check("busy_before_clear", 64'(busy_m), 64'h1);
    clear = 1'b1;
    #1;
    check("clear_flags", {61'h0, busy_m, done_m, dbz_m}, 64'h0);
    check("clear_zhi", 64'(zhi_m), 64'h0);
    check("clear_zlo", 64'(zlo_m), 64'h0);
    check("clear_state", 64'(dbg_m), 64'(S_IDLE));
    @(negedge clock);
    clear = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clock);
      if (done_m || busy_m) dones++;
    end
    check("no_done_after_clear", 64'(dones), 64'h0);
    do_op(OP_ADD, 32'd2, 32'd3, -1);
  endtask

  logic [4:0] op_tab[13] = '{OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND,
                             OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT, 5'b00000};

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(3, 0))
      0:       return 32'($urandom_range(20, 0));
      1:       return -32'($urandom_range(20, 0));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clock);
    check("reset_flags", {61'h0, busy_m, done_m, dbz_m}, 64'h0);
    check("reset_zhi_zlo", {zhi_m, zlo_m}, 64'h0);
    check("reset_state", 64'(dbg_m), 64'(S_IDLE));
    // First start on the first edge with clear low.
    clear = 1'b0;
    do_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, -1);
    do_op(OP_MUL, 32'hFFFF_FFFD, 32'd7, -1);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    do_op(OP_DIV, 32'd5, 32'd0, -1);
    do_op(OP_ROR, 32'h0000_0001, 32'h21, -1);
    do_op(OP_SHR, 32'h8000_0000, 32'd31, -1);
    do_op(OP_MUL, 32'h0001_2345, 32'hFFFF_0F0F, 5);
    do_op(5'b11111, 32'h1234_5678, 32'h9, -1);
    do_op(OP_NEG, 32'h8000_0000, 32'h0, -1);
    do_op(OP_ROL, 32'hA5A5_0001, 32'h20, -1);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, -1);
    do_op(OP_SUB, 32'h0, 32'h1, -1);
    for (int i = 0; i < 60; i++)
      do_op(op_tab[$urandom_range(12, 0)], rand_operand(), rand_operand(),
            ($urandom_range(3, 0) == 0) ? int'($urandom_range(8, 1)) : -1);
    abort_div();

    sel16 = 1'b1;
    @(negedge clock);
    do_op(OP_MUL, 32'h0000_FFFD, 32'd7, -1);
    do_op(OP_DIV, 32'h0000_FFF9, 32'd2, -1);
    do_op(OP_DIV, 32'd5, 32'd0, -1);
    do_op(OP_ROR, 32'h0000_0001, 32'h11, -1);
    do_op(OP_DIV, 32'h0000_8000, 32'h0000_FFFF, -1);
    for (int i = 0; i < 30; i++)
      do_op(op_tab[$urandom_range(12, 0)], rand_operand(), rand_operand(), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
